// File: rtl/clk_en_pkg.sv
// Shared constants and helpers for the clock-enable chain.
package clk_en_pkg;

  localparam int unsigned CLK_HZ_SYS        = 100_000_000;
  localparam int unsigned DIV_1KHZ          = 100000;
  localparam int unsigned DIV_1HZ_FROM_1KHZ = 1000;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(v))) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_en_chain_if.sv
// Control/status bundle of the clock-enable chain.
interface clk_en_chain_if #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 17
);

  logic              i_ce;
  logic              i_sync;
  logic              i_load;
  logic [CNT_W-1:0]  i_div;
  logic [STAGES-1:0] o_tick;
  logic [STAGES-1:0] o_sq;
  logic              o_load_err;

  modport master (
    output i_ce, i_sync, i_load, i_div,
    input  o_tick, o_sq, o_load_err
  );

  modport slave (
    input  i_ce, i_sync, i_load, i_div,
    output o_tick, o_sq, o_load_err
  );

endinterface

// File: rtl/clk_en_stage.sv
// One divider stage: modulo counter with registered tick and 50 % square output.
module clk_en_stage #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sync_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             wrap_o,
  output logic             tick_o,
  output logic             sq_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             half;

  always_comb begin
    wrap_o = inc_i && (cnt_q == div_i - CNT_W'(1));
    half   = inc_i && (cnt_q == (div_i >> 1) - CNT_W'(1));
    cnt_d  = cnt_q;
    tick_d = wrap_o;
    sq_d   = sq_q;
    if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
    if (half || wrap_o) begin
      sq_d = ~sq_q;
    end
    if (sync_i) begin
      cnt_d  = '0;
      tick_d = 1'b0;
      sq_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clk_en_chain.sv
// Cascaded clock-enable generator with runtime reload of the stage-0 divisor.
module clk_en_chain
  import clk_en_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned DIV0   = DIV_1KHZ,
  parameter int unsigned DIVN   = DIV_1HZ_FROM_1KHZ,
  parameter int unsigned CNT_W  = 17
) (
  input logic           i_clk,
  input logic           i_rst,
  clk_en_chain_if.slave bus
);

  localparam int unsigned DivMax = (DIV0 > DIVN) ? DIV0 : DIVN;

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "clk_en_chain: STAGES must be >= 1");
  end
  if ((DIV0 < 2) || (DIV0 % 2 != 0)) begin : g_bad_div0
    $fatal(1, "clk_en_chain: DIV0 must be even and >= 2");
  end
  if ((DIVN < 2) || (DIVN % 2 != 0)) begin : g_bad_divn
    $fatal(1, "clk_en_chain: DIVN must be even and >= 2");
  end
  if ((CNT_W < 2) || (CNT_W < clog2(DivMax))) begin : g_bad_cnt_w
    $fatal(1, "clk_en_chain: CNT_W too narrow for the divisors");
  end

  logic [CNT_W-1:0] d0_q, d0_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  logic             div_ok;
  logic             wrap0;

  // Even and non-zero implies >= 2.
  assign div_ok = ~bus.i_div[0] & (|bus.i_div[CNT_W-1:1]);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             inc;
    logic             wrap;
    logic             tick;
    logic             sq;
    logic [CNT_W-1:0] div;

    if (k == 0) begin : g_first
      assign inc = bus.i_ce;
      assign div = d0_q;
    end else begin : g_next
      assign inc = g_stage[k-1].wrap;
      assign div = CNT_W'(DIVN);
    end

    clk_en_stage #(
      .CNT_W (CNT_W)
    ) u_stage (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .sync_i (bus.i_sync),
      .inc_i  (inc),
      .div_i  (div),
      .wrap_o (wrap),
      .tick_o (tick),
      .sq_o   (sq)
    );

    assign bus.o_tick[k] = tick;
    assign bus.o_sq[k]   = sq;
  end

  assign wrap0 = g_stage[0].wrap;

  // A wrap consumes the old pending value before a coincident load refills it.
  always_comb begin
    d0_d       = d0_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = bus.i_load & ~div_ok;
    if (wrap0 && !bus.i_sync && pend_vld_q) begin
      d0_d       = pend_q;
      pend_vld_d = 1'b0;
    end
    if (bus.i_load && div_ok) begin
      pend_d     = bus.i_div;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      d0_q       <= CNT_W'(DIV0);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      d0_q       <= d0_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_load_err = err_q;

endmodule

// File: tb/tb_clk_en_chain.sv
// Scoreboard bench for clk_en_chain: behavioural model plus directed period checks.
module tb_clk_en_chain;

  localparam int unsigned STAGES = 2;
  localparam int unsigned DIV0   = 4;
  localparam int unsigned DIVN   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned OW     = 2 * STAGES + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clk_en_chain_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

  clk_en_chain #(
    .STAGES (STAGES),
    .DIV0   (DIV0),
    .DIVN   (DIVN),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs;
  int            t0_times[$];
  int            t1_times[$];

  int m_cnt[STAGES];
  bit m_tick[STAGES];
  bit m_sq[STAGES];
  int m_d0, m_pend;
  bit m_pv, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [STAGES-1:0] t, s;
    for (int k = 0; k < STAGES; k++) begin
      t[k] = m_tick[k];
      s[k] = m_sq[k];
    end
    return {t, s, m_err};
  endfunction

  task automatic model_step(input bit r, input bit ce, input bit sy, input bit ld, input int dv);
    bit ok, inc, w, h, w0;
    int d;
    if (r) begin
      for (int k = 0; k < STAGES; k++) begin
        m_cnt[k] = 0; m_tick[k] = 0; m_sq[k] = 0;
      end
      m_d0 = DIV0; m_pend = 0; m_pv = 0; m_err = 0;
    end else begin
      ok    = (dv % 2 == 0) && (dv >= 2);
      m_err = ld && !ok;
      w0    = 0;
      if (sy) begin
        for (int k = 0; k < STAGES; k++) begin
          m_cnt[k] = 0; m_tick[k] = 0; m_sq[k] = 0;
        end
      end else begin
        inc = ce;
        for (int k = 0; k < STAGES; k++) begin
          d = (k == 0) ? m_d0 : DIVN;
          w = inc && (m_cnt[k] == d - 1);
          h = inc && ((m_cnt[k] == d / 2 - 1) || w);
          if (inc) m_cnt[k] = w ? 0 : m_cnt[k] + 1;
          m_tick[k] = w;
          if (h) m_sq[k] = !m_sq[k];
          if (k == 0) w0 = w;
          inc = w;
        end
      end
      if (w0 && m_pv) begin
        m_d0 = m_pend;
        m_pv = 0;
      end
      if (ld && ok) begin
        m_pend = dv;
        m_pv   = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit ce, input bit sy, input bit ld, input int dv);
    logic [31:0] dvv;
    dvv        = dv;
    rst        = r;
    bus.i_ce   = ce;
    bus.i_sync = sy;
    bus.i_load = ld;
    bus.i_div  = dvv[CNT_W-1:0];
    model_step(r, ce, sy, ld, dv);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    obs = {bus.o_tick, bus.o_sq, bus.o_load_err};
    chk("sb", 32'(obs), 32'(exp_q.pop_front()));
  endtask

  // Steps with i_ce=1 until o_tick[0]; n stays 0 if the bound expires.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; (i <= 40) && (n == 0); i++) begin
      step(0, 1, 0, 0, 0);
      if (bus.o_tick[0]) n = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_out", 32'(obs), 32'd0);

    // Free run from reset.
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0);
      if (bus.o_tick[0]) t0_times.push_back(cyc);
      if (bus.o_tick[1]) t1_times.push_back(cyc);
      if (cyc == 2) chk("sq0_rise", 32'(bus.o_sq[0]), 32'd1);
    end
    chk("t0_count", t0_times.size(), 4);
    chk("t0_first", (t0_times.size() > 0) ? t0_times[0] : 0, 4);
    chk("t0_second", (t0_times.size() > 1) ? t0_times[1] : 0, 8);
    chk("t0_third", (t0_times.size() > 2) ? t0_times[2] : 0, 12);
    chk("t1_first", (t1_times.size() > 0) ? t1_times[0] : 0, 16);
    chk("t1_count", t1_times.size(), 1);

    // Pause with cnt_0 = 2.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("pause_sq", 32'(bus.o_sq[0]), 32'd1);
    wait_tick(n);
    chk("pause_resume", n, 2);

    // Reload 6 at cnt_0 = 1.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 6);
    wait_tick(n);
    chk("reload_cur", n, 2);
    wait_tick(n);
    chk("reload_next", n, 6);

    // Load coincident with wrap_0 is deferred a full period.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 4);
    chk("coinc_tick", 32'(bus.o_tick[0]), 32'd1);
    wait_tick(n);
    chk("coinc_defer", n, 6);
    wait_tick(n);
    chk("coinc_apply", n, 4);

    // Rejected divisors.
    step(0, 1, 0, 1, 5);
    chk("err_odd", 32'(bus.o_load_err), 32'd1);
    step(0, 1, 0, 1, 1);
    chk("err_one", 32'(bus.o_load_err), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("err_clear", 32'(bus.o_load_err), 32'd0);
    wait_tick(n);
    wait_tick(n);
    chk("err_keep_div", n, 4);

    // Sync at cnt_0 = 3, cnt_1 = 2.
    found = 0;
    for (int i = 0; (i < 40) && !found; i++) begin
      if (m_cnt[0] == 3 && m_cnt[1] == 2) found = 1;
      else step(0, 1, 0, 0, 0);
    end
    chk("sync_reach", 32'(found), 32'd1);
    step(0, 1, 1, 0, 0);
    chk("sync_out", 32'(obs), 32'd0);
    wait_tick(n);
    chk("sync_restart", n, 4);

    // Reset discards a pending load.
    step(0, 1, 0, 1, 8);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_mid_out", 32'(obs), 32'd0);
    wait_tick(n);
    chk("rst_div_a", n, 4);
    wait_tick(n);
    chk("rst_div_b", n, 4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 10)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
